// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth sequencer and recoder.
// Holds the state encoding, the partial-product mux codes and the recode result type.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] MUX_ZERO = 2'b00;
    localparam logic [1:0] MUX_ONE  = 2'b01;
    localparam logic [1:0] MUX_TWO  = 2'b10;

    typedef struct packed {
        logic [1:0] sel;
        logic       neg;
    } recode_t;

endpackage

// File: rtl/booth_recode.sv
// Radix-4 Booth recoder: maps one overlapping multiplier triple to a mux select and negate flag.
// Purely combinational so it can also be replicated in a parallel Booth array.
module booth_recode
    import booth_pkg::*;
(
    input  logic [2:0] triple,
    output recode_t    rec
);

    always_comb begin
        // NOTE: assign a default before the case so every path drives rec and no latch is inferred.
        rec = '{sel: MUX_ZERO, neg: 1'b0};
        case (triple)
            3'b001, 3'b010: rec = '{sel: MUX_ONE, neg: 1'b0};
            3'b011:         rec = '{sel: MUX_TWO, neg: 1'b0};
            3'b100:         rec = '{sel: MUX_TWO, neg: 1'b1};
            3'b101, 3'b110: rec = '{sel: MUX_ONE, neg: 1'b1};
            default:        rec = '{sel: MUX_ZERO, neg: 1'b0};
        endcase
    end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequencer for a radix-4 Booth multiplier: captures the multiplier, walks N/2 recode
// iterations and drives the multiplicand mux and accumulator strobes.
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int N     = 16,
    parameter int CNT_W = $clog2(N/2) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] multiplier_in,
    output logic         ready,
    output logic         busy,
    output logic         mux_start,
    output logic [1:0]   mux_sel,
    output logic         neg,
    output logic         acc_clr,
    output logic         acc_en,
    output logic         done
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N/2 - 1);

    state_t           r_state;
    logic [N:0]       r_sreg;
    logic [CNT_W-1:0] r_cnt;
    recode_t          w_rec;

    booth_recode u_recode (
        .triple (r_sreg[2:0]),
        .rec    (w_rec)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
        end else if (abort) begin
            r_state <= IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Multiplier is captured only on acceptance, so later input changes are ignored.
                    if (start) begin
                        r_state <= LOAD;
                        r_sreg  <= {multiplier_in, 1'b0};
                        r_cnt   <= '0;
                    end
                end
                LOAD: begin
                    r_state <= RUN;
                    r_cnt   <= '0;
                end
                RUN: begin
                    r_sreg <= {r_sreg[N], r_sreg[N], r_sreg[N:2]};
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_ITER) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs depend only on registered state, so no input reaches an output combinationally.
    always_comb begin
        ready     = (r_state == IDLE);
        busy      = (r_state != IDLE);
        mux_start = (r_state == RUN);
        acc_en    = (r_state == RUN);
        acc_clr   = (r_state == LOAD);
        done      = (r_state == DONE);
        mux_sel   = MUX_ZERO;
        neg       = 1'b0;
        if (r_state == RUN) begin
            mux_sel = w_rec.sel;
            neg     = w_rec.neg;
        end
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl: directed vector table, multi-cycle corner
// sequences and random multipliers against a digit-arithmetic reference model.
module tb_booth_seq_ctrl;

    localparam int N     = 16;
    localparam int ITERS = N / 2;

    typedef enum int { P_IDLE, P_LOAD, P_RUN, P_DONE } phase_t;

    typedef struct {
        logic [15:0] mult;
        logic [15:0] sel_exp;
        logic [7:0]  neg_exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] multiplier_in = '0;
    logic        ready, busy, mux_start, neg, acc_clr, acc_en, done;
    logic [1:0]  mux_sel;

    int checks = 0;
    int errors = 0;

    booth_seq_ctrl #(.N(N), .CNT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .multiplier_in (multiplier_in),
        .ready         (ready),
        .busy          (busy),
        .mux_start     (mux_start),
        .mux_sel       (mux_sel),
        .neg           (neg),
        .acc_clr       (acc_clr),
        .acc_en        (acc_en),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Output word: {ready, busy, mux_start, mux_sel, neg, acc_clr, acc_en, done}
    function automatic logic [8:0] out_vec();
        return {ready, busy, mux_start, mux_sel, neg, acc_clr, acc_en, done};
    endfunction

    function automatic logic [8:0] exp_vec(input phase_t ph, input logic [1:0] sel, input logic ng);
        case (ph)
            P_LOAD:  return 9'b0_1_0_00_0_1_0_0;
            P_RUN:   return {1'b0, 1'b1, 1'b1, sel, ng, 1'b0, 1'b1, 1'b0};
            P_DONE:  return 9'b0_1_0_00_0_0_0_1;
            default: return 9'b1_0_0_00_0_0_0_0;
        endcase
    endfunction

    // Reference: radix-4 digit i = b[2i-1] + b[2i] - 2*b[2i+1], with b[-1] = 0.
    task automatic model(input logic [15:0] m, output logic [15:0] sel, output logic [7:0] ng);
        logic [16:0] ext;
        int d;
        ext = {m, 1'b0};
        sel = '0;
        ng  = '0;
        for (int i = 0; i < ITERS; i++) begin
            d = int'(ext[2*i]) + int'(ext[2*i+1]) - 2 * int'(ext[2*i+2]);
            sel[2*i +: 2] = 2'(d < 0 ? -d : d);
            ng[i] = (d < 0);
        end
    endtask

    // Entered just after a negedge with the DUT idle; leaves just after the IDLE sample.
    task automatic run_op(input string tag, input logic [15:0] m, input logic [15:0] sel_exp,
                          input logic [7:0] neg_exp, input bit repulse);
        int sum;
        int w;
        sum = 0;
        start = 1'b1;
        multiplier_in = m;
        @(negedge clk);
        check({tag, "_load"}, 32'(out_vec()), 32'(exp_vec(P_LOAD, 2'b00, 1'b0)));
        start = 1'b0;
        for (int i = 0; i < ITERS; i++) begin
            @(negedge clk);
            check($sformatf("%s_run%0d", tag, i + 1), 32'(out_vec()),
                  32'(exp_vec(P_RUN, sel_exp[2*i +: 2], neg_exp[i])));
            w = int'(mux_sel) * (4 ** i);
            sum += neg ? -w : w;
            if (i == 0) multiplier_in = 16'($urandom);
            if (repulse && i == 3) begin
                start = 1'b1;
                multiplier_in = 16'h1234;
            end
            if (i == 4) start = 1'b0;
        end
        @(negedge clk);
        check({tag, "_done"}, 32'(out_vec()), 32'(exp_vec(P_DONE, 2'b00, 1'b0)));
        @(negedge clk);
        check({tag, "_idle"}, 32'(out_vec()), 32'(exp_vec(P_IDLE, 2'b00, 1'b0)));
        check({tag, "_sum"}, 32'(sum), 32'(int'($signed(m))));
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (!ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_idle_timeout"}, 32'(ready), 32'd1);
    endtask

    vec_t tbl[6];

    initial begin
        logic [15:0] m, s;
        logic [7:0]  n;

        tbl[0] = '{mult: 16'h0003, sel_exp: 16'h0005, neg_exp: 8'h01};
        tbl[1] = '{mult: 16'h8000, sel_exp: 16'h8000, neg_exp: 8'h80};
        tbl[2] = '{mult: 16'hFFFF, sel_exp: 16'h0001, neg_exp: 8'h01};
        tbl[3] = '{mult: 16'h5555, sel_exp: 16'h5555, neg_exp: 8'h00};
        tbl[4] = '{mult: 16'h0000, sel_exp: 16'h0000, neg_exp: 8'h00};
        tbl[5] = '{mult: 16'h7FFF, sel_exp: 16'h8001, neg_exp: 8'h01};

        // Reset state
        @(negedge clk);
        check("reset", 32'(out_vec()), 32'(exp_vec(P_IDLE, 2'b00, 1'b0)));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 32'(out_vec()), 32'(exp_vec(P_IDLE, 2'b00, 1'b0)));

        for (int t = 0; t < 6; t++) begin
            run_op($sformatf("tbl%0d", t), tbl[t].mult, tbl[t].sel_exp, tbl[t].neg_exp, 1'b0);
        end

        // Start re-pulsed during RUN must not disturb the 0x0003 sequence
        run_op("repulse", 16'h0003, 16'h0005, 8'h01, 1'b1);
        @(negedge clk);
        check("repulse_not_taken", 32'(out_vec()), 32'(exp_vec(P_IDLE, 2'b00, 1'b0)));

        // Start held through DONE: back-to-back with one IDLE cycle gap
        start = 1'b1;
        multiplier_in = 16'h0003;
        @(negedge clk);
        check("b2b_load1", 32'(out_vec()), 32'(exp_vec(P_LOAD, 2'b00, 1'b0)));
        repeat (ITERS) @(negedge clk);
        multiplier_in = 16'h5555;
        @(negedge clk);
        check("b2b_done1", 32'(out_vec()), 32'(exp_vec(P_DONE, 2'b00, 1'b0)));
        @(negedge clk);
        check("b2b_gap", 32'(out_vec()), 32'(exp_vec(P_IDLE, 2'b00, 1'b0)));
        @(negedge clk);
        check("b2b_load2", 32'(out_vec()), 32'(exp_vec(P_LOAD, 2'b00, 1'b0)));
        start = 1'b0;
        @(negedge clk);
        check("b2b_run2_first", 32'(out_vec()), 32'(exp_vec(P_RUN, 2'b01, 1'b0)));
        wait_idle("b2b");

        // Abort at RUN cycle 4
        start = 1'b1;
        multiplier_in = 16'h0003;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_run4", 32'(out_vec()), 32'(exp_vec(P_RUN, 2'b00, 1'b0)));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle", 32'(out_vec()), 32'(exp_vec(P_IDLE, 2'b00, 1'b0)));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("abort_no_done%0d", i), 32'(out_vec()), 32'(exp_vec(P_IDLE, 2'b00, 1'b0)));
        end

        // Abort and start together in IDLE: request dropped
        start = 1'b1;
        abort = 1'b1;
        multiplier_in = 16'h0003;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_idle", 32'(out_vec()), 32'(exp_vec(P_IDLE, 2'b00, 1'b0)));
        @(negedge clk);
        check("abort_start_idle2", 32'(out_vec()), 32'(exp_vec(P_IDLE, 2'b00, 1'b0)));

        // Reset asserted at RUN cycle 4 of a fresh operation
        start = 1'b1;
        multiplier_in = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_run4", 32'(out_vec()), 32'(exp_vec(P_RUN, 2'b00, 1'b0)));
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_idle", 32'(out_vec()), 32'(exp_vec(P_IDLE, 2'b00, 1'b0)));
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("rst_no_done%0d", i), 32'(out_vec()), 32'(exp_vec(P_IDLE, 2'b00, 1'b0)));
        end

        // Operation after abort/reset still complete and correct
        run_op("post_rst", 16'h8000, 16'h8000, 8'h80, 1'b0);

        // Random multipliers against the digit model
        for (int r = 0; r < 40; r++) begin
            m = 16'($urandom);
            model(m, s, n);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op($sformatf("rnd%0d", r), m, s, n, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
